// File: rtl/snell_pkg.sv
// Shared types and widths for the Snell's-law refraction controller.
// Holds the controller state set, the latched job payload and the sine scaling helper.
package snell_pkg;

    localparam int unsigned ANG_W  = 7;
    localparam int unsigned SIN_W  = 9;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned PROD_W = 13;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [3:0] {
        IDLE,
        S1_ISSUE,
        S1_WAIT,
        TIR_ISSUE,
        TIR_WAIT,
        TIR_CMP,
        BS_ISSUE,
        BS_WAIT,
        BS_CMP,
        FIN
    } state_t;

    typedef struct packed {
        logic [ANG_W-1:0] theta1;
        logic [IDX_W-1:0] n1;
        logic [IDX_W-1:0] n2;
    } snell_job_t;

    // sin value scaled by a refractive index, kept at full product width
    function automatic logic [PROD_W-1:0] scale_sin(input logic [SIN_W-1:0] s,
                                                    input logic [IDX_W-1:0] n);
        return PROD_W'(s) * PROD_W'(n);
    endfunction

endpackage

// File: rtl/snell_lat_cnt.sv
// Down-counter that times the wait for the external sine unit.
// Loaded on each sine issue; expire_c is high once the count has drained to zero.
module snell_lat_cnt
    import snell_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire_c = (cnt == '0);

endmodule

// File: rtl/snell_ctrl.sv
// Refraction-angle controller: finds the largest theta2 with sin(theta2)*n2 <= sin(theta1)*n1
// by binary search over a shared, externally instantiated sine unit.
module snell_ctrl
    import snell_pkg::*;
#(
    parameter int unsigned SIN_LAT = 1,
    parameter int unsigned ANG_MAX = 90
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ANG_W-1:0] theta1,
    input  logic [IDX_W-1:0] n1,
    input  logic [IDX_W-1:0] n2,
    output logic [ANG_W-1:0] sin_x,
    input  logic [SIN_W-1:0] sin_y,
    output logic             busy,
    output logic             done,
    output logic [ANG_W-1:0] theta2,
    output logic             tir,
    output logic             err
);

    localparam logic [ANG_W-1:0] ANG_MAX_V = ANG_W'(ANG_MAX);
    // WAIT states span SIN_LAT cycles; the sample is taken in the state that follows
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(SIN_LAT - 1);

    state_t           state, next_state;
    snell_job_t       job, job_d;
    logic [PROD_W-1:0] target, target_d;
    logic [ANG_W-1:0] lo, hi, mid;
    logic [ANG_W-1:0] lo_d, hi_d, mid_d;
    logic [ANG_W-1:0] sin_x_d, theta2_d;
    logic             tir_d, err_d;
    logic             cnt_load;
    logic             expire_c;
    logic             illegal_c;
    logic [ANG_W:0]   sum_c;
    logic [ANG_W-1:0] mid_c;
    logic [PROD_W-1:0] prod_c;

    snell_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .expire_c (expire_c)
    );

    assign illegal_c = (theta1 > ANG_MAX_V) || (n1 == '0) || (n2 == '0);
    assign sum_c     = {1'b0, lo} + {1'b0, hi} + (ANG_W+1)'(1);
    assign mid_c     = ANG_W'(sum_c >> 1);
    assign prod_c    = scale_sin(sin_y, job.n2);

    // State register and registered datapath/outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            job    <= '0;
            target <= '0;
            lo     <= '0;
            hi     <= '0;
            mid    <= '0;
            sin_x  <= '0;
            theta2 <= '0;
            tir    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= next_state;
            job    <= job_d;
            target <= target_d;
            lo     <= lo_d;
            hi     <= hi_d;
            mid    <= mid_d;
            sin_x  <= sin_x_d;
            theta2 <= theta2_d;
            tir    <= tir_d;
            err    <= err_d;
            busy   <= (next_state != IDLE) && (next_state != FIN);
            done   <= (next_state == FIN);
        end
    end

    // Next-state and datapath update
    always_comb begin
        next_state = state;
        job_d      = job;
        target_d   = target;
        lo_d       = lo;
        hi_d       = hi;
        mid_d      = mid;
        sin_x_d    = sin_x;
        theta2_d   = theta2;
        tir_d      = tir;
        err_d      = err;
        cnt_load   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    job_d    = '{theta1: theta1, n1: n1, n2: n2};
                    theta2_d = '0;
                    tir_d    = 1'b0;
                    err_d    = 1'b0;
                    if (illegal_c) begin
                        err_d      = 1'b1;
                        next_state = FIN;
                    end else begin
                        next_state = S1_ISSUE;
                    end
                end
            end
            S1_ISSUE: begin
                sin_x_d    = job.theta1;
                cnt_load   = 1'b1;
                next_state = S1_WAIT;
            end
            S1_WAIT: begin
                if (expire_c) next_state = TIR_ISSUE;
            end
            TIR_ISSUE: begin
                // sin_y still reflects theta1 here; sin_x only moves on this edge
                target_d   = scale_sin(sin_y, job.n1);
                sin_x_d    = ANG_MAX_V;
                cnt_load   = 1'b1;
                next_state = TIR_WAIT;
            end
            TIR_WAIT: begin
                if (expire_c) next_state = TIR_CMP;
            end
            TIR_CMP: begin
                if (prod_c < target) begin
                    tir_d      = 1'b1;
                    theta2_d   = ANG_MAX_V;
                    next_state = FIN;
                end else begin
                    lo_d       = '0;
                    hi_d       = ANG_MAX_V;
                    next_state = BS_ISSUE;
                end
            end
            BS_ISSUE: begin
                mid_d      = mid_c;
                sin_x_d    = mid_c;
                cnt_load   = 1'b1;
                next_state = BS_WAIT;
            end
            BS_WAIT: begin
                if (expire_c) next_state = BS_CMP;
            end
            BS_CMP: begin
                if (prod_c <= target) begin
                    lo_d = mid;
                end else begin
                    hi_d = mid - ANG_W'(1);
                end
                if (lo_d == hi_d) begin
                    theta2_d   = lo_d;
                    next_state = FIN;
                end else begin
                    next_state = BS_ISSUE;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_snell_ctrl.sv
// Bench for snell_ctrl: two instances (sine latency 1 and 3) each fed by a rounded-sine model,
// checked every cycle against a linear-search reference plus directed literal expectations.
module tb_snell_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] theta1 = '0;
    logic [3:0] n1 = '0;
    logic [3:0] n2 = '0;

    logic [6:0] sinx_w [2];
    logic [8:0] siny_w [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [6:0] th2_w  [2];
    logic       tir_w  [2];
    logic       err_w  [2];

    int sin_tab [128];

    snell_ctrl #(.SIN_LAT(1), .ANG_MAX(90)) dut_l1 (
        .clk(clk), .rst(rst), .start(start), .theta1(theta1), .n1(n1), .n2(n2),
        .sin_x(sinx_w[0]), .sin_y(siny_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .theta2(th2_w[0]), .tir(tir_w[0]), .err(err_w[0])
    );

    snell_ctrl #(.SIN_LAT(3), .ANG_MAX(90)) dut_l3 (
        .clk(clk), .rst(rst), .start(start), .theta1(theta1), .n1(n1), .n2(n2),
        .sin_x(sinx_w[1]), .sin_y(siny_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .theta2(th2_w[1]), .tir(tir_w[1]), .err(err_w[1])
    );

    // Sine units: rounded 256*sin(deg) behind 1 and 3 register stages
    logic [8:0] s0, s1a, s1b, s1c;
    always @(posedge clk) begin
        if (rst) begin
            s0 <= '0; s1a <= '0; s1b <= '0; s1c <= '0;
        end else begin
            s0  <= 9'(sin_tab[sinx_w[0]]);
            s1a <= 9'(sin_tab[sinx_w[1]]);
            s1b <= s1a;
            s1c <= s1b;
        end
    end
    assign siny_w[0] = s0;
    assign siny_w[1] = s1c;

    function automatic int bnd(input int i);
        return 9 * (((i == 0) ? 1 : 3) + 2) + 2;
    endfunction

    // Reference: largest angle whose scaled sine does not exceed the incident product
    function automatic void ref_snell(input int t1, input int a, input int b,
                                      output int th2, output int tr, output int er);
        int tgt;
        th2 = 0; tr = 0; er = 0;
        if (t1 > 90 || a == 0 || b == 0) begin
            er = 1;
            return;
        end
        tgt = sin_tab[t1] * a;
        if (sin_tab[90] * b < tgt) begin
            tr = 1; th2 = 90;
            return;
        end
        for (int x = 0; x <= 90; x++) if (sin_tab[x] * b <= tgt) th2 = x;
    endfunction

    int checks = 0;
    int errors = 0;

    int m_active [2] = '{0, 0};
    int m_cyc    [2] = '{0, 0};
    int m_e_th   [2] = '{0, 0};
    int m_e_tir  [2] = '{0, 0};
    int m_e_err  [2] = '{0, 0};
    int m_th     [2] = '{0, 0};
    int m_tir    [2] = '{0, 0};
    int m_err    [2] = '{0, 0};
    int m_sx     [2] = '{0, 0};
    int m_sx_pre [2] = '{0, 0};

    int    lit_kind [64];
    int    lit_idx  [64];
    int    lit_a    [64];
    int    lit_b    [64];
    int    lit_c    [64];
    string lit_name [64];
    int    ln = 0;
    int    lk = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d want %0d at %0t", nm, idx, act, exp, $time);
        end
    endtask

    // Compare process: model state reflects the last rising edge; inputs seen here feed the next
    always @(negedge clk) begin
        bit jd;
        int lat;
        for (int i = 0; i < 2; i++) begin
            jd = 1'b0;
            if (m_active[i] != 0) begin
                if (done_w[i]) begin
                    chk("theta2", i, int'(th2_w[i]), m_e_th[i]);
                    chk("tir", i, int'(tir_w[i]), m_e_tir[i]);
                    chk("err", i, int'(err_w[i]), m_e_err[i]);
                    chk("busy_at_done", i, int'(busy_w[i]), 0);
                    lat = m_cyc[i] + 1;
                    checks++;
                    if (lat > bnd(i) || (m_e_err[i] != 0 && lat != 1)) begin
                        errors++;
                        $display("FAIL latency dut%0d got %0d want <=%0d (1 if err)", i, lat, bnd(i));
                    end
                    if (m_e_err[i] != 0) chk("sinx_untouched", i, int'(sinx_w[i]), m_sx_pre[i]);
                    m_th[i]  = m_e_th[i];
                    m_tir[i] = m_e_tir[i];
                    m_err[i] = m_e_err[i];
                    m_sx[i]  = int'(sinx_w[i]);
                    m_active[i] = 0;
                    jd = 1'b1;
                end else begin
                    chk("busy", i, int'(busy_w[i]), 1);
                    if (m_cyc[i] + 1 > bnd(i)) begin
                        chk("done_within_bound", i, m_cyc[i] + 1, bnd(i));
                        m_active[i] = 0;
                        m_sx[i] = int'(sinx_w[i]);
                    end
                end
            end else begin
                chk("idle_done", i, int'(done_w[i]), 0);
                chk("idle_busy", i, int'(busy_w[i]), 0);
                chk("hold_theta2", i, int'(th2_w[i]), m_th[i]);
                chk("hold_tir", i, int'(tir_w[i]), m_tir[i]);
                chk("hold_err", i, int'(err_w[i]), m_err[i]);
                chk("hold_sinx", i, int'(sinx_w[i]), m_sx[i]);
            end

            if (rst) begin
                m_active[i] = 0; m_cyc[i] = 0;
                m_th[i] = 0; m_tir[i] = 0; m_err[i] = 0; m_sx[i] = 0;
            end else if (!jd) begin
                if (m_active[i] != 0) begin
                    m_cyc[i]++;
                end else if (start) begin
                    m_active[i] = 1;
                    m_cyc[i]    = 0;
                    m_sx_pre[i] = int'(sinx_w[i]);
                    ref_snell(int'(theta1), int'(n1), int'(n2), m_e_th[i], m_e_tir[i], m_e_err[i]);
                end
            end
        end

        while (lk < ln) begin
            case (lit_kind[lk])
                0: begin
                    chk({lit_name[lk], "_theta2"}, lit_idx[lk], int'(th2_w[lit_idx[lk]]), lit_a[lk]);
                    chk({lit_name[lk], "_tir"}, lit_idx[lk], int'(tir_w[lit_idx[lk]]), lit_b[lk]);
                    chk({lit_name[lk], "_err"}, lit_idx[lk], int'(err_w[lit_idx[lk]]), lit_c[lk]);
                end
                1: chk(lit_name[lk], 0, sin_tab[lit_a[lk]], lit_b[lk]);
                default: chk(lit_name[lk], 0, lit_a[lk], 0);
            endcase
            lk++;
        end
    end

    task automatic push_lit(input int kind, input int idx, input int a, input int b,
                            input int c, input string nm);
        lit_kind[ln] = kind; lit_idx[ln] = idx;
        lit_a[ln] = a; lit_b[ln] = b; lit_c[ln] = c; lit_name[ln] = nm;
        ln++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int t, input int a, input int b);
        theta1 = 7'(t); n1 = 4'(a); n2 = 4'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        theta1 = 7'($urandom); n1 = 4'($urandom); n2 = 4'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((m_active[0] != 0 || m_active[1] != 0) && k < 300) begin
            tick();
            k++;
        end
        push_lit(2, 0, (k >= 300) ? 1 : 0, 0, 0, {nm, "_idle_timeout"});
    endtask

    task automatic run(input int t, input int a, input int b, input int th,
                       input int tr, input int er, input string nm);
        pulse(t, a, b);
        wait_idle(nm);
        push_lit(0, 0, th, tr, er, nm);
        push_lit(0, 1, th, tr, er, nm);
        tick();
    endtask

    initial begin
        int k;
        for (int a = 0; a < 128; a++)
            sin_tab[a] = (a <= 90) ? $rtoi($floor(256.0 * $sin(a * 3.14159265358979 / 180.0) + 0.5)) : 0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        push_lit(1, 0, 30, 128, 0, "sin30");
        push_lit(1, 0, 45, 181, 0, "sin45");
        push_lit(1, 0, 20, 88, 0, "sin20");
        push_lit(1, 0, 60, 222, 0, "sin60");
        push_lit(1, 0, 90, 256, 0, "sin90");

        run(30, 1, 1, 30, 0, 0, "basic30");
        run(45, 1, 2, 20, 0, 0, "t45_n2");
        run(30, 2, 1, 90, 0, 0, "equal_sin90");
        run(60, 3, 2, 90, 1, 0, "tir");
        run(0, 5, 3, 0, 0, 0, "zero");
        run(95, 1, 1, 0, 0, 1, "ang_over");
        run(30, 1, 0, 0, 0, 1, "n2_zero");
        run(90, 1, 15, 3, 0, 0, "n2_15");
        run(10, 15, 1, 90, 1, 0, "tir_n1_15");
        run(0, 0, 4, 0, 0, 1, "n1_zero");

        // second start while busy is dropped
        pulse(30, 1, 1);
        repeat (4) tick();
        pulse(45, 1, 2);
        wait_idle("busy_start");
        push_lit(0, 0, 30, 0, 0, "busy_start");
        push_lit(0, 1, 30, 0, 0, "busy_start");
        tick();

        // start in the cycle right after done on the latency-1 instance
        pulse(45, 1, 2);
        k = 0;
        while (!done_w[0] && k < 300) begin
            tick();
            k++;
        end
        push_lit(2, 0, (k >= 300) ? 1 : 0, 0, 0, "done_wait_timeout");
        tick();
        pulse(60, 3, 2);
        wait_idle("after_done");
        push_lit(0, 0, 90, 1, 0, "after_done");
        push_lit(0, 1, 20, 0, 0, "after_done");
        tick();

        // reset in the middle of the search, with start held during reset
        pulse(45, 1, 2);
        repeat (14) tick();
        rst = 1'b1;
        theta1 = 7'd30; n1 = 4'd1; n2 = 4'd1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        repeat (60) tick();
        push_lit(0, 0, 0, 0, 0, "mid_reset");
        push_lit(0, 1, 0, 0, 0, "mid_reset");
        tick();

        run(45, 1, 2, 20, 0, 0, "post_reset");

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
